// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular exponentiation sequencer and its
// Montgomery-product handshake.
package mod_exp_ctrl_pkg;

    localparam int unsigned BIT_LEN_DEFAULT     = 64;
    localparam int unsigned COUNT_WIDTH_DEFAULT = 5;
    localparam int unsigned EXP_WIDTH_DEFAULT   = 64;

    typedef enum logic [2:0] {
        IDLE,
        CONV_X,
        CONV_ONE,
        SQUARE,
        MULT,
        CONV_OUT,
        DONE
    } exp_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_WAIT,
        TX_REDUCE,
        TX_RELEASE
    } tx_state_t;

endpackage

// File: rtl/mod_exp_ctrl_mp_handshake.sv
// One mon_prod transaction per req: issue, wait for stop, reduce the
// product into [0, M), then wait for stop to fall before acknowledging.
module mp_handshake
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned bitLen     = BIT_LEN_DEFAULT,
    parameter int unsigned countWidth = COUNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [bitLen-1:0]     op_a,
    input  logic [bitLen-1:0]     op_b,
    input  logic [bitLen-1:0]     op_m,
    input  logic [countWidth-1:0] op_num_words,
    output logic                  ack,
    output logic [bitLen-1:0]     res,
    output logic                  mp_start,
    output logic [bitLen-1:0]     mp_A,
    output logic [bitLen-1:0]     mp_B,
    output logic [bitLen-1:0]     mp_M,
    output logic [countWidth-1:0] mp_num_words,
    input  logic                  mp_stop,
    input  logic [bitLen:0]       mp_P
);

    tx_state_t         tx_state;
    tx_state_t         tx_next;
    logic [bitLen:0]   p_q;
    logic [bitLen:0]   m_ext;
    logic [bitLen:0]   diff;

    assign m_ext = {1'b0, mp_M};
    assign diff  = p_q - m_ext;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:    if (req)      tx_next = TX_ISSUE;
            TX_ISSUE:   if (!mp_stop) tx_next = TX_WAIT;
            TX_WAIT:    if (mp_stop)  tx_next = TX_REDUCE;
            TX_REDUCE:                tx_next = TX_RELEASE;
            TX_RELEASE: if (!mp_stop) tx_next = TX_IDLE;
            default:                  tx_next = TX_IDLE;
        endcase
    end

    // start is a pure state decode so it drops the cycle after stop is seen
    assign mp_start = (tx_state == TX_WAIT);
    assign ack      = (tx_state == TX_RELEASE) && !mp_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            mp_A         <= '0;
            mp_B         <= '0;
            mp_M         <= '0;
            mp_num_words <= '0;
            p_q          <= '0;
            res          <= '0;
        end else begin
            if (tx_state == TX_IDLE && req) begin
                mp_A         <= op_a;
                mp_B         <= op_b;
                mp_M         <= op_m;
                mp_num_words <= op_num_words;
            end
            if (tx_state == TX_WAIT && mp_stop) p_q <= mp_P;
            if (tx_state == TX_REDUCE)
                res <= (p_q >= m_ext) ? diff[bitLen-1:0] : p_q[bitLen-1:0];
        end
    end

endmodule

// File: rtl/mod_exp_ctrl.sv
// X^E mod M by left-to-right square-and-multiply in the Montgomery domain,
// driving a shared external mon_prod through mp_handshake.
module mod_exp_ctrl
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned bitLen     = BIT_LEN_DEFAULT,
    parameter int unsigned countWidth = COUNT_WIDTH_DEFAULT,
    parameter int unsigned expWidth   = EXP_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [bitLen-1:0]     X,
    input  logic [expWidth-1:0]   E,
    input  logic [bitLen-1:0]     M,
    input  logic [bitLen-1:0]     R2,
    input  logic [countWidth-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic [bitLen-1:0]     result,
    output logic                  mp_start,
    output logic [bitLen-1:0]     mp_A,
    output logic [bitLen-1:0]     mp_B,
    output logic [bitLen-1:0]     mp_M,
    output logic [countWidth-1:0] mp_num_words,
    input  logic                  mp_stop,
    input  logic [bitLen:0]       mp_P
);

    localparam int unsigned       IDX_W   = (expWidth > 1) ? $clog2(expWidth) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(expWidth - 1);
    localparam logic [bitLen-1:0] ONE     = {{(bitLen-1){1'b0}}, 1'b1};

    exp_state_t            state;
    exp_state_t            state_next;
    logic [bitLen-1:0]     x_q, m_q, r2_q, xb_q, ab_q;
    logic [expWidth-1:0]   e_q;
    logic [countWidth-1:0] nw_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  inflight_q;
    logic                  is_op;
    logic                  req;
    logic                  ack;
    logic [bitLen-1:0]     op_a, op_b, hs_res;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        op_a       = '0;
        op_b       = '0;
        is_op      = 1'b0;
        case (state)
            IDLE: if (start) state_next = CONV_X;
            CONV_X: begin
                is_op = 1'b1; op_a = x_q; op_b = r2_q;
                if (ack) state_next = CONV_ONE;
            end
            CONV_ONE: begin
                is_op = 1'b1; op_a = ONE; op_b = r2_q;
                if (ack) state_next = SQUARE;
            end
            SQUARE: begin
                is_op = 1'b1; op_a = ab_q; op_b = ab_q;
                if (ack) begin
                    if (e_q[idx_q])         state_next = MULT;
                    else if (idx_q == '0)   state_next = CONV_OUT;
                end
            end
            MULT: begin
                is_op = 1'b1; op_a = ab_q; op_b = xb_q;
                if (ack) state_next = (idx_q == '0) ? CONV_OUT : SQUARE;
            end
            CONV_OUT: begin
                is_op = 1'b1; op_a = ab_q; op_b = ONE;
                if (ack) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // one request per step; inflight blocks re-issue until the ack arrives
    assign req  = is_op && !inflight_q;
    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0; m_q <= '0; r2_q <= '0; xb_q <= '0; ab_q <= '0;
            e_q <= '0; nw_q <= '0; idx_q <= '0; inflight_q <= 1'b0;
            result <= '0;
        end else begin
            if (state == IDLE && start) begin
                x_q   <= X;
                e_q   <= E;
                m_q   <= M;
                r2_q  <= R2;
                nw_q  <= num_words;
                idx_q <= IDX_TOP;
            end
            if (req)      inflight_q <= 1'b1;
            else if (ack) inflight_q <= 1'b0;
            if (ack) begin
                case (state)
                    CONV_X:   xb_q   <= hs_res;
                    CONV_OUT: result <= hs_res;
                    default:  ab_q   <= hs_res;
                endcase
                if (idx_q != '0 && ((state == SQUARE && !e_q[idx_q]) || state == MULT))
                    idx_q <= idx_q - 1'b1;
            end
        end
    end

    mp_handshake #(
        .bitLen     (bitLen),
        .countWidth (countWidth)
    ) u_hs (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_m         (m_q),
        .op_num_words (nw_q),
        .ack          (ack),
        .res          (hs_res),
        .mp_start     (mp_start),
        .mp_A         (mp_A),
        .mp_B         (mp_B),
        .mp_M         (mp_M),
        .mp_num_words (mp_num_words),
        .mp_stop      (mp_stop),
        .mp_P         (mp_P)
    );

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural mon_prod responder.
module tb_mod_exp_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] X, E, M, R2;
    logic [4:0]  num_words;
    logic        busy, done, mp_start, mp_stop;
    logic [63:0] result, mp_A, mp_B, mp_M;
    logic [4:0]  mp_num_words;
    logic [64:0] mp_P;

    int checks = 0;
    int errors = 0;
    int tx_count = 0;
    int extra_hold = 0;
    int done_count = 0;
    int pushed = 0;
    bit plus_m = 1'b0;
    logic [63:0] exp_res_q[$];
    int          exp_tx_q[$];
    logic        prev_start = 1'b0;
    logic        stop_at_edge = 1'b0;

    always #5 clk = ~clk;

    mod_exp_ctrl #(
        .bitLen     (64),
        .countWidth (5),
        .expWidth   (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .X            (X),
        .E            (E),
        .M            (M),
        .R2           (R2),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mp_start     (mp_start),
        .mp_A         (mp_A),
        .mp_B         (mp_B),
        .mp_M         (mp_M),
        .mp_num_words (mp_num_words),
        .mp_stop      (mp_stop),
        .mp_P         (mp_P)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // A*B*2^-64 mod m, bit-serial, result in [0, 2m)
    function automatic logic [64:0] mont(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
        logic [65:0] p = '0;
        for (int i = 0; i < 64; i++) begin
            if (a[i]) p = p + {2'b00, b};
            if (p[0]) p = p + {2'b00, m};
            p = p >> 1;
        end
        return p[64:0];
    endfunction

    // mon_prod responder
    initial begin : model
        logic [63:0] a, b, m;
        logic [64:0] pm;
        int n;
        mp_stop = 1'b0;
        mp_P    = '0;
        forever begin
            @(negedge clk);
            if (mp_start && !mp_stop) begin
                a = mp_A; b = mp_B; m = mp_M;
                tx_count++;
                check("mp_M", 128'(mp_M), 128'(253));
                check("mp_num_words", 128'(mp_num_words), 128'(2));
                repeat ($urandom_range(1, 20)) @(negedge clk);
                check("operands_stable", {mp_A, mp_B}, {a, b});
                pm = mont(a, b, m);
                if (pm >= {1'b0, m}) pm = pm - {1'b0, m};
                if (plus_m) pm = pm + {1'b0, m};
                mp_P    = pm;
                mp_stop = 1'b1;
                n = 0;
                while (mp_start && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check("start_drop_latency", 128'(n), 128'(1));
                repeat ($urandom_range(1, 3) + extra_hold) @(negedge clk);
                mp_stop = 1'b0;
            end
        end
    end

    always @(posedge clk) stop_at_edge <= mp_stop;

    // protocol and result monitor
    always @(negedge clk) begin
        if (mp_start && !prev_start)
            check("start_with_stop_low", 128'(stop_at_edge), 128'(0));
        prev_start <= mp_start;
        if (done) begin
            done_count++;
            check("busy_low_at_done", 128'(busy), 128'(0));
            if (exp_res_q.size() == 0) begin
                check("unexpected_done", 128'(1), 128'(0));
            end else begin
                check("result", 128'(result), 128'(exp_res_q.pop_front()));
                check("transactions", 128'(tx_count), 128'(exp_tx_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [63:0] x, input logic [63:0] e,
                         input logic [63:0] res_exp, input int tx_exp, input bit push);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tx_count  = 0;
        X         = x;
        E         = e;
        M         = 64'd253;
        R2        = 64'd36;
        num_words = 5'd2;
        start     = 1'b1;
        if (push) begin
            exp_res_q.push_back(res_exp);
            exp_tx_q.push_back(tx_exp);
            pushed++;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 128'(busy), 128'(1));
    endtask

    task automatic wait_done(input logic [63:0] res_exp);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 128'(done), 128'(1));
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'(0));
        @(negedge clk);
        check("result_hold", 128'(result), 128'(res_exp));
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst = 1'b1; start = 1'b0;
        X = '0; E = '0; M = '0; R2 = '0; num_words = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_result", 128'(result), 128'(0));
        check("reset_mp_start", 128'(mp_start), 128'(0));
        check("reset_mp_ops", {mp_A, mp_B}, 128'(0));
        check("reset_mp_M", 128'(mp_M), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // table of directed vectors, M=253, R2=2^128 mod 253=36
        issue(64'd123, 64'd3,  64'd52,  69, 1'b1); wait_done(64'd52);
        issue(64'd2,   64'd10, 64'd12,  69, 1'b1); wait_done(64'd12);
        issue(64'd216, 64'd1,  64'd216, 68, 1'b1); wait_done(64'd216);
        issue(64'd216, 64'd0,  64'd1,   67, 1'b1); wait_done(64'd1);

        plus_m = 1'b1;
        issue(64'd123, 64'd3,  64'd52,  69, 1'b1); wait_done(64'd52);
        issue(64'd2,   64'd10, 64'd12,  69, 1'b1); wait_done(64'd12);
        plus_m = 1'b0;

        // reset while the 10th product is being returned
        issue(64'd123, 64'd3, 64'd52, 69, 1'b0);
        n = 0;
        while (!(tx_count == 10 && mp_stop) && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_tx10", 128'(tx_count), 128'(10));
        extra_hold = 8;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_busy", 128'(busy), 128'(0));
        check("midreset_mp_start", 128'(mp_start), 128'(0));
        @(negedge clk);
        issue(64'd2, 64'd10, 64'd12, 69, 1'b1);
        wait_done(64'd12);
        extra_hold = 0;

        // start pulsed while busy must be ignored
        issue(64'd123, 64'd3, 64'd52, 69, 1'b1);
        repeat (5) @(negedge clk);
        X = 64'd216; E = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(64'd52);

        repeat (5) @(negedge clk);
        check("done_count", 128'(done_count), 128'(pushed));
        check("scoreboard_empty", 128'(exp_res_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
